// File: rtl/serial_tx_fifo.sv
// Buffered 8N1 serial transmitter: an octet FIFO feeding a gapless frame
// serializer that can also hold the line in break on request.
module serial_tx_fifo #(
  parameter int CLK_FREQ   = 48_000_000,
  parameter int BIT_FREQ   = 115_200,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            data,
  input  logic                  wr,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  brk,
  output logic                  idle,
  output logic                  tx
);

  localparam int BIT_TICKS = CLK_FREQ / BIT_FREQ;
  localparam int CW        = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam int CNTW      = DEPTH_LOG2 + 1;
  localparam int DEPTH     = 1 << DEPTH_LOG2;

  localparam logic [CW-1:0]   BAUD_LAST = CW'(BIT_TICKS - 1);
  localparam logic [CNTW-1:0] CNT_FULL  = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] CNT_ZERO  = CNTW'(0);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;
  localparam logic [2:0] S_MARK  = 3'd5;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [CNTW-1:0]       count_q, count_d;
  logic                  full_q, full_d;
  logic                  ovf_q, ovf_d;
  logic                  push_s, pop_s;

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         baud_q, baud_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            sr_q, sr_d;
  logic                  tx_q, tx_d;
  logic                  baud_end_s, decide_s;

  assign push_s     = wr & ~full_q;
  assign baud_end_s = (baud_q == BAUD_LAST);

  // FIFO bookkeeping; overflow is judged on the registered full flag
  always_comb begin
    if (push_s) begin
      wptr_d = wptr_q + DEPTH_LOG2'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + DEPTH_LOG2'(1);
    end else begin
      rptr_d = rptr_q;
    end
    count_d = count_q + CNTW'(push_s) - CNTW'(pop_s);
    full_d  = (count_d == CNT_FULL);
    ovf_d   = ovf_q | (wr & full_q);
  end

  // FIFO state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
    end
  end

  // Octet storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wptr_q] <= data;
    end
  end

  // Frame sequencer; STOP and MARK end on the same edge as the next IDLE decision
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    sr_d     = sr_q;
    tx_d     = tx_q;
    pop_s    = 1'b0;
    decide_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        decide_s = 1'b1;
      end
      S_START: begin
        if (baud_end_s) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = sr_q[0];
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      S_DATA: begin
        if (baud_end_s) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            sr_d  = {1'b0, sr_q[7:1]};
            tx_d  = sr_q[1];
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      S_STOP, S_MARK: begin
        if (baud_end_s) begin
          decide_s = 1'b1;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      S_BREAK: begin
        if (brk) begin
          tx_d = 1'b0;
        end else begin
          state_d = S_MARK;
          baud_d  = '0;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase

    if (decide_s) begin
      baud_d = '0;
      if (brk) begin
        state_d = S_BREAK;
        tx_d    = 1'b0;
      end else if (count_q != CNT_ZERO) begin
        pop_s   = 1'b1;
        sr_d    = mem_q[rptr_q];
        state_d = S_START;
        tx_d    = 1'b0;
      end else begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    end else begin
      pop_s = 1'b0;
    end
  end

  // Sequencer registers; reset drives the line high without waiting for a clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      sr_q    <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      tx_q    <= tx_d;
    end
  end

  assign full     = full_q;
  assign count    = count_q;
  assign overflow = ovf_q;
  assign tx       = tx_q;
  assign idle     = (state_q == S_IDLE) && (count_q == CNT_ZERO) && !brk;

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Scoreboard bench for serial_tx_fifo: a queue-level model predicts FIFO flags
// and frame start edges; a line monitor decodes tx and checks against them.
module tb_serial_tx_fifo;

  localparam int BT      = 10;
  localparam int DL2     = 2;
  localparam int DEPTH   = 4;
  localparam int FRAME   = 10 * BT;
  localparam int BRK_LEN = 50;

  typedef struct {
    bit         is_brk;
    logic [7:0] b;
    int         start;
  } item_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [7:0]     data = 8'h00;
  logic           wr = 1'b0;
  logic           brk = 1'b0;
  logic           full, overflow, idle, tx;
  logic [DL2:0]   count;

  int             tests = 0;
  int             fails = 0;
  int             edge_n = 0;

  item_t          sb[$];
  logic [7:0]     mq[$];
  int             free_at = 0;
  bit             movf = 1'b0;
  bit             model_en = 1'b1;

  serial_tx_fifo #(
    .CLK_FREQ  (1_000_000),
    .BIT_FREQ  (100_000),
    .DEPTH_LOG2(DL2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data    (data),
    .wr      (wr),
    .full    (full),
    .count   (count),
    .overflow(overflow),
    .brk     (brk),
    .idle    (idle),
    .tx      (tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // One clock: drive at negedge, advance the model for the coming edge, check after it
  task automatic cycle(input logic w, input logic [7:0] d, input logic b);
    int    e;
    int    cnt_b;
    item_t it;
    @(negedge clk);
    wr   = w;
    data = d;
    brk  = b;
    if (model_en) begin
      e     = edge_n + 1;
      cnt_b = mq.size();
      if (cnt_b > 0 && e >= free_at) begin
        it.is_brk = 1'b0;
        it.b      = mq.pop_front();
        it.start  = e;
        sb.push_back(it);
        free_at   = e + FRAME;
      end
      if (w) begin
        if (cnt_b < DEPTH) mq.push_back(d);
        else movf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (model_en) begin
      check("count", 32'(count), 32'(mq.size()));
      check("full", 32'(full), 32'(mq.size() == DEPTH));
      check("overflow", 32'(overflow), 32'(movf));
      check("idle", 32'(idle), 32'(mq.size() == 0 && edge_n >= free_at));
    end
  endtask

  task automatic drain();
    int n = 0;
    while (!(mq.size() == 0 && edge_n >= free_at) && n < 3000) begin
      cycle(1'b0, 8'h00, 1'b0);
      n++;
    end
    check("drain_in_time", 32'(n < 3000), 32'd1);
    repeat (3) cycle(1'b0, 8'h00, 1'b0);
  endtask

  // Line monitor: every falling edge of tx must match the head of the scoreboard
  initial begin : monitor
    item_t      it;
    int         bad;
    int         low;
    int         slot;
    int         wt;
    logic       eb;
    logic [7:0] dec;
    bit         abort;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        check("frame_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) begin
          wt = 0;
          while (tx === 1'b0 && wt < 2000) begin
            @(negedge clk);
            wt++;
          end
        end else begin
          it = sb.pop_front();
          check("start_edge", 32'(edge_n), 32'(it.start));
          if (it.is_brk) begin
            low = 1;
            while (low < 1000) begin
              @(negedge clk);
              if (rst_n !== 1'b1 || tx !== 1'b0) break;
              low++;
            end
            check("break_low_len", 32'(low), 32'(BRK_LEN));
          end else begin
            bad   = 0;
            dec   = 8'h00;
            abort = 1'b0;
            for (int mi = 1; mi < FRAME; mi++) begin
              @(negedge clk);
              if (rst_n !== 1'b1) begin
                abort = 1'b1;
                break;
              end
              slot = mi / BT;
              if (slot == 0) eb = 1'b0;
              else if (slot == 9) eb = 1'b1;
              else eb = it.b[slot-1];
              if (tx !== eb) bad++;
              if ((mi % BT) == (BT / 2) && slot >= 1 && slot <= 8) dec[slot-1] = tx;
            end
            if (!abort) begin
              check("frame_shape", 32'(bad), 32'd0);
              check("frame_byte", 32'(dec), 32'(it.b));
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", edge_n);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int    k;
    int    s;
    int    n;
    int    i;
    item_t it;

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) cycle(1'b0, 8'h00, 1'b0);

    // single byte, then a back-to-back burst
    cycle(1'b1, 8'h55, 1'b0);
    drain();
    cycle(1'b1, 8'h00, 1'b0);
    cycle(1'b1, 8'hFF, 1'b0);
    cycle(1'b1, 8'hA5, 1'b0);
    drain();

    // fill past capacity: sixth write is dropped
    for (int j = 1; j <= 6; j++) cycle(1'b1, 8'(j), 1'b0);
    drain();

    // break requested mid-frame with a second octet queued
    model_en = 1'b0;
    k = edge_n + 1;
    it.is_brk = 1'b0; it.b = 8'h3C; it.start = k + 1;   sb.push_back(it);
    it.is_brk = 1'b1; it.b = 8'h00; it.start = k + 101; sb.push_back(it);
    it.is_brk = 1'b0; it.b = 8'h81; it.start = k + 161; sb.push_back(it);
    cycle(1'b1, 8'h3C, 1'b0);
    cycle(1'b1, 8'h81, 1'b0);
    for (int j = 2; j <= 270; j++) begin
      cycle(1'b0, 8'h00, (j >= 20 && j <= 150));
      if (j == 60)  check("brk_count_queued", 32'(count), 32'd1);
      if (j == 120) check("brk_tx_low", 32'(tx), 32'd0);
      if (j == 120) check("brk_idle_low", 32'(idle), 32'd0);
      if (j == 155) check("mark_tx_high", 32'(tx), 32'd1);
    end
    check("brk_overflow_kept", 32'(overflow), 32'd1);
    model_en = 1'b1;
    free_at  = 0;
    drain();

    // reset during data bit 3 with two octets queued
    k = edge_n + 1;
    s = k + 1;
    cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b1, 8'h5A, 1'b0);
    cycle(1'b1, 8'hC3, 1'b0);
    while (edge_n < s + 45) cycle(1'b0, 8'h00, 1'b0);
    check("bit3_tx_before_rst", 32'(tx), 32'd0);
    #1 rst_n = 1'b0;
    mq.delete();
    movf    = 1'b0;
    free_at = 0;
    #1;
    check("rst_tx_async", 32'(tx), 32'd1);
    repeat (2) cycle(1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    #1;
    check("post_rst_count", 32'(count), 32'd0);
    check("post_rst_overflow", 32'(overflow), 32'd0);
    check("post_rst_idle", 32'(idle), 32'd1);
    repeat (300) cycle(1'b0, 8'h00, 1'b0);

    // pointer wrap: ten octets, each written only while the model says not full
    i = 0;
    n = 0;
    while (i < 10 && n < 3000) begin
      if (mq.size() < DEPTH) begin
        cycle(1'b1, 8'(8'h10 + i), 1'b0);
        i++;
      end else begin
        cycle(1'b0, 8'h00, 1'b0);
      end
      n++;
    end
    drain();
    check("wrap_overflow", 32'(overflow), 32'd0);

    // random writes, including drops when full
    for (int j = 0; j < 400; j++) begin
      cycle(($urandom_range(0, 2) == 0), 8'($urandom), 1'b0);
    end
    drain();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
